elixirchip_es1_spu_op_acc: RTL and testbench
============================================

Name: elixirchip_es1_spu_op_acc

Overview:
Accumulator SPU op, placed directly downstream of elixirchip_es1_spu_op_nop in the ES1 SPU op pipeline.
- Consumes the nop stage's data, clear and valid signals.
- Keeps a running wrap-around sum with a carry flag.
- Presents the sum after a programmable pipeline delay, using the same cke/clear/valid semantics as the other spu_op blocks.

Parameters:
LATENCY, 1, total cycles from input sample to output; legal range 1..8; 0 is illegal (elaboration $error).
DATA_BITS, 8, width of s_data, m_data and the accumulator.
data_t, logic [DATA_BITS-1:0], data type.
CLEAR_DATA, '0, value loaded into the accumulator on clear or reset.
DEVICE, "RTL", target device name; no behavioural effect.
SIMULATION, "false", simulation switch; no behavioural effect.
DEBUG, "false", debug switch; no behavioural effect.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous reset, active-high.
cke  input  1  clock enable; all state advances only when cke=1.
s_data  input  DATA_BITS  addend.
s_clear  input  1  clear the accumulator.
s_valid  input  1  s_data is valid; add it.
m_data  output  DATA_BITS  accumulated value, delayed.
m_carry  output  1  sticky carry: set by any add overflow since the last clear.
m_valid  output  1  m_data/m_carry were updated at the last cke edge.

Behaviour:
Interface:
- One clock, clk.
- reset is synchronous and active-high.
- reset takes effect at a clk edge regardless of cke.

Reset values:
- Accumulator and every pipeline data stage = CLEAR_DATA.
- Carry and every pipeline carry stage = 0.
- Valid pipeline = 0.
- m_data = CLEAR_DATA, m_carry = 0, m_valid = 0.

Stage 0, the accumulator register. On a clk edge with cke=1 and reset=0:
- s_clear=1, s_valid=0: acc <= CLEAR_DATA; carry <= 0.
- s_clear=1, s_valid=1: acc <= s_data; carry <= 0 (clear first, then add onto zero; no CLEAR_DATA term).
- s_clear=0, s_valid=1: {c, acc} <= acc + s_data (DATA_BITS+1-bit add); carry <= carry | c. The sum wraps modulo 2^DATA_BITS.
- s_clear=0, s_valid=0: acc and carry hold.
- Stage-0 valid flag <= s_clear | s_valid.

Stages 1..LATENCY-1, each cke edge:
- Stage k valid <= stage k-1 valid.
- Stage k data/carry load from stage k-1 only when stage k-1 valid=1; otherwise they hold.

Outputs:
- m_data, m_carry, m_valid are driven by stage LATENCY-1, combinationally from registers (no output logic).
- An input sampled at cke edge t appears on the outputs after cke edge t+LATENCY-1.

cke behaviour:
- cke=0 freezes all state, including valid flags; m_valid holds its last value.
- The output timing therefore counts cke-enabled edges only.

Stability:
- m_data and m_carry change only at an edge where the stage LATENCY-2 valid (or, for LATENCY=1, the input s_clear|s_valid) is 1.
- The bench asserts $stable(m_data) whenever no update is due.

Back-to-back:
- Valid on every cycle is supported, with no bubbles.
- Each output sample reflects exactly one input update, in order.

Reset mid-operation:
- All in-flight results are discarded.
- The first valid output after reset is derived only from inputs sampled after reset.

Test Plan:
1. LATENCY=1, DATA_BITS=8, CLEAR_DATA=0: reset, then s_valid with 3, 4, 5 on consecutive cke cycles -> m_data = 3, 7, 12 on successive edges, m_carry=0.
2. Wrap: clear, then add 200, then 100 -> m_data 200, then 44; m_carry goes to 1 and stays 1 through a further add of 1 (m_data=45). A later s_clear alone -> m_data=0, m_carry=0.
3. Simultaneous: acc=50, apply s_clear=1, s_valid=1, s_data=9 -> m_data=9, m_carry=0. Repeat with CLEAR_DATA=8'h10 -> still 9; s_clear alone -> 8'h10.
4. LATENCY=4, cke toggling 1,0,1,0...: add 1, 2, 3 -> outputs 1, 3, 6 appear after 4 cke-enabled edges each. m_data stable while cke=0 and on non-valid cycles.
5. Reset mid-pipeline: LATENCY=3, two adds in flight, assert reset for one edge -> m_valid=0, m_data=CLEAR_DATA. The next add of 7 -> m_data=7 three edges later.
6. Randomized DATA_BITS=16, LATENCY=1..8: random valid/clear/cke -> matches a reference model, with m_data held whenever no update is due.

Source files
------------

// File: rtl/elixirchip_es1_spu_op_acc.sv
// ES1 SPU accumulator op: running wrap-around sum with a sticky carry,
// presented through a LATENCY-deep, cke-gated pipeline.
module elixirchip_es1_spu_op_acc #(
  parameter int       LATENCY    = 1,
  parameter int       DATA_BITS  = 8,
  parameter type      data_t     = logic [DATA_BITS-1:0],
  parameter data_t    CLEAR_DATA = '0,
  parameter           DEVICE     = "RTL",
  parameter           SIMULATION = "false",
  parameter           DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_clear,
  input  logic                 s_valid,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_carry,
  output logic                 m_valid
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_latency_check
    $error("elixirchip_es1_spu_op_acc: LATENCY must be in 1..8");
  end

  // Target/debug options are accepted for interface compatibility only.
  if (DEVICE == "" || SIMULATION == "" || DEBUG == "") begin : g_unused_options
  end

  data_t              r_data [LATENCY];
  logic [LATENCY-1:0] r_carry;
  logic [LATENCY-1:0] r_valid;
  logic [DATA_BITS:0] w_sum;

  assign w_sum = {1'b0, r_data[0]} + {1'b0, s_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_data[k] <= CLEAR_DATA;
      end
      r_carry <= '0;
      r_valid <= '0;
    end else if (cke) begin
      // A simultaneous clear and add starts from zero, not from CLEAR_DATA.
      if (s_clear) begin
        r_data[0]  <= s_valid ? s_data : CLEAR_DATA;
        r_carry[0] <= 1'b0;
      end else if (s_valid) begin
        r_data[0]  <= w_sum[DATA_BITS-1:0];
        r_carry[0] <= r_carry[0] | w_sum[DATA_BITS];
      end
      r_valid[0] <= s_clear | s_valid;

      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) begin
          r_data[k]  <= r_data[k-1];
          r_carry[k] <= r_carry[k-1];
        end
      end
    end
  end

  assign m_data  = r_data[LATENCY-1];
  assign m_carry = r_carry[LATENCY-1];
  assign m_valid = r_valid[LATENCY-1];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Self-checking bench for elixirchip_es1_spu_op_acc: directed scenarios on
// 8-bit instances plus a randomized 16-bit bank covering LATENCY 1..8.
module tb_elixirchip_es1_spu_op_acc;

  logic        clk;
  logic        reset;
  logic        cke;
  logic        sClear;
  logic        sValid;
  logic [15:0] sData;

  logic [7:0]  l1Data, l1cData, l4Data, l3Data;
  logic        l1Carry, l1cCarry, l4Carry, l3Carry;
  logic        l1Valid, l1cValid, l4Valid, l3Valid;

  logic [8:1][15:0] rdData;
  logic [8:1]       rdCarry;
  logic [8:1]       rdValid;

  int nChecks = 0;
  int nFail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8)) u_l1 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(sData[7:0]), .s_clear(sClear),
    .s_valid(sValid), .m_data(l1Data), .m_carry(l1Carry), .m_valid(l1Valid));

  elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8), .CLEAR_DATA(8'h10)) u_l1c (
    .clk(clk), .reset(reset), .cke(cke), .s_data(sData[7:0]), .s_clear(sClear),
    .s_valid(sValid), .m_data(l1cData), .m_carry(l1cCarry), .m_valid(l1cValid));

  elixirchip_es1_spu_op_acc #(.LATENCY(4), .DATA_BITS(8)) u_l4 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(sData[7:0]), .s_clear(sClear),
    .s_valid(sValid), .m_data(l4Data), .m_carry(l4Carry), .m_valid(l4Valid));

  elixirchip_es1_spu_op_acc #(.LATENCY(3), .DATA_BITS(8)) u_l3 (
    .clk(clk), .reset(reset), .cke(cke), .s_data(sData[7:0]), .s_clear(sClear),
    .s_valid(sValid), .m_data(l3Data), .m_carry(l3Carry), .m_valid(l3Valid));

  for (genvar g = 1; g <= 8; g++) begin : g_rnd
    elixirchip_es1_spu_op_acc #(.LATENCY(g), .DATA_BITS(16)) u_dut (
      .clk(clk), .reset(reset), .cke(cke), .s_data(sData), .s_clear(sClear),
      .s_valid(sValid), .m_data(rdData[g]), .m_carry(rdCarry[g]), .m_valid(rdValid[g]));
  end

  // Drive one clock edge's worth of inputs, then settle just past the edge.
  task automatic applyStimulus(input logic c, input logic clr, input logic v,
                               input logic [15:0] d, input logic rst);
    cke    = c;
    sClear = clr;
    sValid = v;
    sData  = d;
    reset  = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    nChecks++;
    if (l1Data !== 8'd0 || l1Carry !== 1'b0 || l1Valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_l1: got d=%0d c=%b v=%b, want d=0 c=0 v=0", l1Data, l1Carry, l1Valid);
    end
    nChecks++;
    if (l1cData !== 8'h10 || l1cCarry !== 1'b0 || l1cValid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_l1c: got d=%h c=%b v=%b, want d=10 c=0 v=0", l1cData, l1cCarry, l1cValid);
    end
    nChecks++;
    if (l4Data !== 8'd0 || l4Carry !== 1'b0 || l4Valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_l4: got d=%0d c=%b v=%b, want d=0 c=0 v=0", l4Data, l4Carry, l4Valid);
    end
    nChecks++;
    if (rdData !== '0 || rdCarry !== '0 || rdValid !== '0) begin
      nFail++;
      $display("[TB] FAIL reset_bank: got v=%b c=%b, want v=0 c=0 with all data 0", rdValid, rdCarry);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] expD;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    expD = 8'd0;
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 16'(i), 1'b0);
      expD = expD + 8'(i);
      nChecks++;
      if (l1Data !== expD || l1Carry !== 1'b0 || l1Valid !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL accumulate_%0d: got d=%0d c=%b v=%b, want d=%0d c=0 v=1",
                 i, l1Data, l1Carry, l1Valid, expD);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] addends [4];
    logic [7:0] expD [4];
    logic       expC [4];
    addends = '{8'd200, 8'd100, 8'd1, 8'd0};
    expD    = '{8'd200, 8'd44, 8'd45, 8'd45};
    expC    = '{1'b0, 1'b1, 1'b1, 1'b1};
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
    nChecks++;
    if (l1Data !== 8'd0 || l1Carry !== 1'b0 || l1Valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL wrap_clear: got d=%0d c=%b v=%b, want d=0 c=0 v=1", l1Data, l1Carry, l1Valid);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, (i != 3), {8'd0, addends[i]}, 1'b0);
      nChecks++;
      if (l1Data !== expD[i] || l1Carry !== expC[i] || l1Valid !== (i != 3)) begin
        nFail++;
        $display("[TB] FAIL wrap_step%0d: got d=%0d c=%b v=%b, want d=%0d c=%b v=%b",
                 i, l1Data, l1Carry, l1Valid, expD[i], expC[i], (i != 3));
      end
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd77, 1'b0);
    nChecks++;
    if (l1Data !== 8'd0 || l1Carry !== 1'b0 || l1Valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL wrap_reclear: got d=%0d c=%b v=%b, want d=0 c=0 v=1", l1Data, l1Carry, l1Valid);
    end
  endtask

  task automatic test_simultaneous();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd50, 1'b0);
    nChecks++;
    if (l1Data !== 8'd50 || l1cData !== 8'h42) begin
      nFail++;
      $display("[TB] FAIL simul_setup: got l1=%0d l1c=%h, want l1=50 l1c=42", l1Data, l1cData);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 16'd9, 1'b0);
    nChecks++;
    if (l1Data !== 8'd9 || l1Carry !== 1'b0 || l1cData !== 8'd9 || l1cCarry !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL simul_clear_add: got l1=%0d/%b l1c=%0d/%b, want 9/0 9/0",
               l1Data, l1Carry, l1cData, l1cCarry);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 16'd33, 1'b0);
    nChecks++;
    if (l1Data !== 8'd0 || l1cData !== 8'h10 || l1cValid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL simul_clear_only: got l1=%0d l1c=%h v=%b, want l1=0 l1c=10 v=1",
               l1Data, l1cData, l1cValid);
    end
  endtask

  // cke-disabled edges carry junk clear/valid that must be ignored.
  task automatic test_cke_latency4();
    int         n;
    logic [7:0] expD;
    logic       expV;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    n    = 0;
    expD = 8'd0;
    expV = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        n++;
        applyStimulus(1'b1, 1'b0, (n <= 3), 16'(n), 1'b0);
        expV = (n >= 4 && n <= 6);
        if (expV) expD = expD + 8'(n - 3);
      end else begin
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h00AA, 1'b0);
      end
      nChecks++;
      if (l4Data !== expD || l4Valid !== expV || l4Carry !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL cke_l4_i%0d: got d=%0d v=%b c=%b, want d=%0d v=%b c=0",
                 i, l4Data, l4Valid, l4Carry, expD, expV);
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd6, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd99, 1'b1);
    nChecks++;
    if (l3Data !== 8'd0 || l3Valid !== 1'b0 || l3Carry !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midreset_flush: got d=%0d v=%b c=%b, want d=0 v=0 c=0", l3Data, l3Valid, l3Carry);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    nChecks++;
    if (l3Data !== 8'd0 || l3Valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midreset_gap: got d=%0d v=%b, want d=0 v=0", l3Data, l3Valid);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    nChecks++;
    if (l3Data !== 8'd7 || l3Valid !== 1'b1 || l3Carry !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midreset_first: got d=%0d v=%b c=%b, want d=7 v=1 c=0", l3Data, l3Valid, l3Carry);
    end
  endtask

  // Reference: history of accumulator state per enabled edge since reset;
  // a latency-L output shows the latest updated state at least L-1 edges old.
  task automatic test_random();
    logic [15:0] hAcc   [0:2047];
    logic        hCarry [0:2047];
    logic        hValid [0:2047];
    int          n, idx;
    logic [15:0] acc, d, expD;
    logic        carry, c, clr, v, rst, expC, expV;
    logic [16:0] sum;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    n = 0; acc = 16'd0; carry = 1'b0;
    hAcc[0] = 16'd0; hCarry[0] = 1'b0; hValid[0] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      c   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      v   = ($urandom_range(0, 1) == 1);
      d   = 16'($urandom);
      if (rst) begin
        n = 0; acc = 16'd0; carry = 1'b0;
      end else if (c) begin
        if (clr) begin
          acc   = v ? d : 16'd0;
          carry = 1'b0;
        end else if (v) begin
          sum   = {1'b0, acc} + {1'b0, d};
          acc   = sum[15:0];
          carry = carry | sum[16];
        end
        n++;
        hAcc[n] = acc; hCarry[n] = carry; hValid[n] = clr | v;
      end
      applyStimulus(c, clr, v, d, rst);
      for (int g = 1; g <= 8; g++) begin
        idx  = n - (g - 1);
        expV = (idx >= 1) ? hValid[idx] : 1'b0;
        expD = 16'd0;
        expC = 1'b0;
        for (int m = idx; m >= 1; m--) begin
          if (hValid[m]) begin
            expD = hAcc[m];
            expC = hCarry[m];
            break;
          end
        end
        nChecks++;
        if (rdData[g] !== expD || rdCarry[g] !== expC || rdValid[g] !== expV) begin
          nFail++;
          $display("[TB] FAIL random_L%0d_i%0d: got d=%h c=%b v=%b, want d=%h c=%b v=%b",
                   g, i, rdData[g], rdCarry[g], rdValid[g], expD, expC, expV);
        end
      end
    end
  endtask

  initial begin
    cke = 1'b0; sClear = 1'b0; sValid = 1'b0; sData = 16'd0; reset = 1'b1;
    test_reset();
    test_accumulate();
    test_wrap();
    test_simultaneous();
    test_cke_latency4();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
